// File: rtl/nbit_serial_adder_subtractor.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a carry register between chunks.
// Optional signed saturation of Result on overflow when ADDSUB_SATURATE_EN is defined.
module nbit_serial_adder_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("WIDTH must be >= 1 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic     [WIDTH-1:0]     a_q, a_d;
    logic     [WIDTH-1:0]     b_q, b_d;
    logic     [WIDTH-1:0]     sum_q, sum_d;
    logic     [WIDTH-1:0]     result_q, result_d;
    logic     [CNT_W-1:0]     cnt_q, cnt_d;
    logic                     carry_q, carry_d;
    logic                     cout_q, cout_d;
    logic                     ovf_q, ovf_d;

    logic     [CHUNK:0]       chunk_sum;
    logic     [WIDTH+CHUNK-1:0] sum_cat;
    logic     [WIDTH-1:0]     full_sum;
    logic                     last_chunk;
    logic                     ovf_now;

`ifdef ADDSUB_SATURATE_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s, input logic ovf);
        logic [WIDTH-1:0] max_pos;
        max_pos = {WIDTH{1'b1}} >> 1;
        if (!ovf) return s;
        // A set sign bit on overflow means the true result was positive.
        return s[WIDTH-1] ? max_pos : ~max_pos;
    endfunction
`endif

    // Operands shift right each RUN edge so the active chunk always sits at bit 0;
    // the sum shifts in from the top, so after N edges it is in place, LSB chunk first.
    assign chunk_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_q};
    assign sum_cat    = {chunk_sum[CHUNK-1:0], sum_q};
    assign full_sum   = sum_cat[WIDTH+CHUNK-1:CHUNK];
    assign last_chunk = (cnt_q == CNT_W'(N - 1));
    assign ovf_now    = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (full_sum[WIDTH-1] != a_q[CHUNK-1]);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = subtract ? ~B : B;
                    carry_d = subtract;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                sum_d   = full_sum;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_chunk) begin
                    state_d = DONE;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = ovf_now;
`ifdef ADDSUB_SATURATE_EN
                    result_d = saturate(full_sum, ovf_now);
`else
                    result_d = full_sum;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign Result   = result_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;

endmodule
